// File: rtl/alu_pkg.sv
// Shared types and operation codes for the execute-stage ALU.
package alu_pkg;

    typedef logic [31:0] u32;
    typedef logic [2:0]  u3;
    typedef logic        u1;

    // Bit 2 of every code selects inverted B (and subtract mode in the adder).
    localparam u3 ALU_AND  = 3'b000;
    localparam u3 ALU_OR   = 3'b001;
    localparam u3 ALU_ADD  = 3'b010;
    localparam u3 ALU_RSVD = 3'b011;
    localparam u3 ALU_RAND = 3'b100;
    localparam u3 ALU_ROR  = 3'b101;
    localparam u3 ALU_SUB  = 3'b110;
    localparam u3 ALU_SLT  = 3'b111;

endpackage

// File: rtl/alu_adder.sv
// Combinational 32-bit add/subtract with carry-out and signed-overflow detection.
module alu_adder
    import alu_pkg::*;
(
    input  u32 a,
    input  u32 b,
    input  u1  sub,
    output u32 sum,
    output u1  cout,
    output u1  ovf
);

    u32          b_eff;
    logic [32:0] full;

    always_comb begin
        b_eff = sub ? ~b : b;
        full  = {1'b0, a} + {1'b0, b_eff} + {32'b0, sub};
        sum   = full[31:0];
        cout  = full[32];
        // Same-sign operands producing an opposite-sign sum.
        ovf   = (a[31] == b_eff[31]) && (full[31] != a[31]);
    end

endmodule

// File: rtl/alu.sv
// Registered 32-bit ALU: logic ops, add/sub, signed set-less-than, with zero/carry/overflow flags.
module alu
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  ALUcont,
    output logic [31:0] result,
    output logic        zero,
    output logic        carry,
    output logic        overflow
);

    u32 b_eff;
    u32 sum;
    u1  cout;
    u1  ovf;
    u32 result_d;
    u1  carry_d;
    u1  overflow_d;
    u1  slt;

    alu_adder u_adder (
        .a    (A),
        .b    (B),
        .sub  (ALUcont[2]),
        .sum  (sum),
        .cout (cout),
        .ovf  (ovf)
    );

    always_comb begin
        b_eff      = ALUcont[2] ? ~B : B;
        // Sign of the true difference, valid even when the subtraction overflows.
        slt        = sum[31] ^ ovf;
        result_d   = '0;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        unique case (ALUcont)
            ALU_AND, ALU_RAND: result_d = A & b_eff;
            ALU_OR,  ALU_ROR:  result_d = A | b_eff;
            ALU_ADD, ALU_SUB: begin
                result_d   = sum;
                carry_d    = cout;
                overflow_d = ovf;
            end
            ALU_SLT: begin
                result_d = {31'b0, slt};
                carry_d  = cout;
            end
            ALU_RSVD: result_d = '0;
            default:  result_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result   <= '0;
            zero     <= 1'b1;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            result   <= result_d;
            zero     <= (result_d == '0);
            carry    <= carry_d;
            overflow <= overflow_d;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the registered ALU.
module tb_alu;
    import alu_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  ALUcont;
    logic [31:0] result;
    logic        zero;
    logic        carry;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    // Packed {result, zero, carry, overflow} expected after the last edge.
    logic [34:0] prev;

    alu dut (
        .clk      (clk),
        .reset    (reset),
        .A        (A),
        .B        (B),
        .ALUcont  (ALUcont),
        .result   (result),
        .zero     (zero),
        .carry    (carry),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [34:0] pack(input u32 r, input bit z, input bit c, input bit o);
        return {r, z, c, o};
    endfunction

    task automatic chk(input string tag, input logic [34:0] exp);
        logic [34:0] obs;
        obs = {result, zero, carry, overflow};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed result=%h z=%b c=%b o=%b expected result=%h z=%b c=%b o=%b",
                   tag, obs[34:3], obs[2], obs[1], obs[0], exp[34:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Drive operands at negedge, confirm outputs still hold the previous value,
    // then confirm the new value one edge later.
    task automatic step(input string tag, input u32 a, input u32 b, input u3 op,
                        input u32 er, input bit ez, input bit ec, input bit eo);
        @(negedge clk);
        A = a;
        B = b;
        ALUcont = op;
        #1;
        chk({tag, "_hold"}, prev);
        @(posedge clk);
        #1;
        chk(tag, pack(er, ez, ec, eo));
        prev = pack(er, ez, ec, eo);
    endtask

    initial begin
        reset = 1'b1;
        A = '0;
        B = '0;
        ALUcont = ALU_AND;
        repeat (2) @(posedge clk);
        #1;
        prev = pack(32'd0, 1'b1, 1'b0, 1'b0);
        chk("reset_state", prev);
        @(negedge clk);
        reset = 1'b0;

        // Chained sequence.
        step("and",      32'd2,  32'd7,         ALU_AND,  32'd2,  0, 0, 0);
        step("or",       32'd2,  32'd4,         ALU_OR,   32'd6,  0, 0, 0);
        step("add",      32'd6,  32'd3,         ALU_ADD,  32'd9,  0, 0, 0);
        step("rand",     32'd9,  32'd1,         ALU_RAND, 32'd8,  0, 0, 0);
        step("ror",      32'd8,  32'hFFFF_FFF8, ALU_ROR,  32'd15, 0, 0, 0);
        step("sub",      32'd15, 32'd4,         ALU_SUB,  32'd11, 0, 1, 0);
        step("slt_lt",   32'd11, 32'd12,        ALU_SLT,  32'd1,  0, 0, 0);
        step("slt_eq",   32'd11, 32'd11,        ALU_SLT,  32'd0,  1, 1, 0);

        // Reset held two cycles while an ADD is presented.
        @(negedge clk);
        reset = 1'b1;
        A = 32'd5;
        B = 32'd5;
        ALUcont = ALU_ADD;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("reset_hold", pack(32'd0, 1'b1, 1'b0, 1'b0));
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_release_hold", pack(32'd0, 1'b1, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        chk("first_after_reset", pack(32'd10, 1'b0, 1'b0, 1'b0));
        prev = pack(32'd10, 1'b0, 1'b0, 1'b0);

        // Boundary arithmetic.
        step("add_wrap", 32'hFFFF_FFFF, 32'd1, ALU_ADD, 32'd0,         1, 1, 0);
        step("add_ovf",  32'h7FFF_FFFF, 32'd1, ALU_ADD, 32'h8000_0000, 0, 0, 1);

        // Signed SLT across sign boundaries.
        step("slt_min_max", 32'h8000_0000, 32'h7FFF_FFFF, ALU_SLT, 32'd1, 0, 1, 0);
        step("slt_max_min", 32'h7FFF_FFFF, 32'h8000_0000, ALU_SLT, 32'd0, 1, 0, 0);
        step("slt_neg1_0",  32'hFFFF_FFFF, 32'd0,         ALU_SLT, 32'd1, 0, 1, 0);

        // Subtraction flags.
        step("sub_borrow", 32'd3,         32'd5, ALU_SUB, 32'hFFFF_FFFE, 0, 0, 0);
        step("sub_nobor",  32'd5,         32'd3, ALU_SUB, 32'd2,         0, 1, 0);
        step("sub_ovf",    32'h8000_0000, 32'd1, ALU_SUB, 32'h7FFF_FFFF, 0, 1, 1);

        // Back-to-back: a different op each cycle on the same operands.
        step("b2b_and",  32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_AND,  32'h00F0_00F0, 0, 0, 0);
        step("b2b_or",   32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_OR,   32'hFFF0_FFF0, 0, 0, 0);
        step("b2b_add",  32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_ADD,  32'h00E1_00E0, 0, 1, 0);
        step("b2b_rsvd", 32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_RSVD, 32'd0,         1, 0, 0);
        step("b2b_rand", 32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_RAND, 32'hF000_F000, 0, 0, 0);
        step("b2b_ror",  32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_ROR,  32'hF0FF_F0FF, 0, 0, 0);
        step("b2b_sub",  32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_SUB,  32'hE100_E100, 0, 1, 0);
        step("b2b_slt",  32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_SLT,  32'd1,         0, 1, 0);

        // Reserved code with operands that would otherwise give a nonzero sum.
        step("rsvd", 32'd5, 32'd5, ALU_RSVD, 32'd0, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
